uart2wifi_core_regbridge: RTL and testbench
===========================================

Name: uart2wifi_core_regbridge

Overview:
- Register-access responder that sits between the UART receive/transmit byte paths and the register file.
- Decodes command frames arriving as RX bytes and issues single-cycle register write/read strobes.
- Returns an ACK/NAK byte, or read data, as TX bytes, honouring TX backpressure.
- Lets a remote host (e.g. the WiFi module) reach the same registers the core uses internally.

Parameters:
- NUM_REGS, 3, number of implemented register addresses; address >= NUM_REGS is rejected.
- DATA_W, 32, register width; must be a multiple of 8. BYTES = DATA_W/8.
- RD_LATENCY, 1, cycles from reg_read strobe to valid reg_rdata.
- TIMEOUT_CYCLES, 163*16*11, max clk cycles between bytes inside one frame (about 11 bit times at 19200 baud).

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset; asynchronous, active-high.
- rx_valid, input, 1, one-cycle pulse: rx_data holds a received byte.
- rx_data, input, 8, received byte.
- tx_full, input, 1, TX path cannot accept a byte this cycle.
- tx_wr, output, 1, one-cycle write strobe into the TX path.
- tx_data, output, 8, byte to transmit; valid when tx_wr=1.
- reg_addr, output, 7, register address.
- reg_wdata, output, DATA_W, write data.
- reg_write, output, 1, one-cycle write strobe.
- reg_read, output, 1, one-cycle read strobe.
- reg_rdata, input, DATA_W, read data; valid RD_LATENCY cycles after reg_read.
- busy, output, 1, high in any state other than IDLE.

Behaviour:
- Reset (async): all outputs 0; state=IDLE; byte counter, timeout counter and shift register cleared.
  - Reset mid-frame discards the frame; no strobes are issued and no response is sent.
- Frame format: CMD byte, where bit7=1 means write and bit7=0 means read, and bits[6:0] are the address.
  - Write frames follow CMD with BYTES data bytes, LSB first.
- FSM states:
  - IDLE: on rx_valid, latch CMD. Write goes to GET_DATA. Read with a legal address goes to DO_READ. Read with an illegal address goes to SEND_RESP with 0x55.
  - GET_DATA: shift each rx_valid byte into wdata at position byte_cnt. After byte BYTES-1, go to DO_WRITE if the address is legal, otherwise to SEND_RESP with 0x55. The data bytes are consumed before the NAK is sent.
  - DO_WRITE: reg_write=1 for exactly 1 cycle, with reg_addr/reg_wdata stable. Next state is SEND_RESP with 0xAA.
  - DO_READ: reg_read=1 for exactly 1 cycle. Next state is WAIT_RD.
  - WAIT_RD: count RD_LATENCY cycles, capture reg_rdata into the shift register, then go to SEND_DATA with byte_cnt=0.
  - SEND_RESP: when tx_full=0, assert tx_wr for 1 cycle with the response byte, then go to IDLE.
  - SEND_DATA: when tx_full=0, issue tx_wr with byte byte_cnt (LSB first). Go to IDLE after BYTES bytes.
- Latency:
  - Write: last data byte to reg_write is 1 cycle; reg_write to ACK tx_wr is 1 cycle if tx_full=0.
  - Read: CMD rx_valid to reg_read is 1 cycle; first tx_wr follows RD_LATENCY+1 cycles after reg_read.
- Timeout: in GET_DATA, a counter resets on every rx_valid. Reaching TIMEOUT_CYCLES returns the FSM to IDLE silently.
- rx_valid in any state other than IDLE/GET_DATA: the byte is dropped. A sticky internal overrun flag is set; it is cleared only by reset.
- tx_full held high: the FSM stalls indefinitely in its send state (no timeout) with tx_wr=0.
- Never asserts reg_write and reg_read in the same cycle; never asserts more than one tx_wr per cycle.

Optional Feature:
- Macro: UART2WIFI_REGBRIDGE_CSUM_EN.
- Defined:
  - Every frame carries a trailing checksum byte equal to the XOR of all preceding frame bytes; a new state GET_CSUM receives it.
  - Mismatch: no strobe is issued; respond 0x55.
  - Read responses append an XOR checksum byte after the data.
- Undefined: no checksum byte in either direction; GET_CSUM logic is absent.

Decomposition:
- Package uart2wifi_core_pkg holds:
  - the FSM state enum,
  - ACK_BYTE=8'hAA, NAK_BYTE=8'h55,
  - CMD_WR_BIT=7.
- Sub-module uart2wifi_core_bytetimer: a loadable down-counter with an expired flag, used for the inter-byte timeout.

Test Plan:
- Write: rx bytes 0x81,0x78,0x56,0x34,0x12 -> one reg_write with addr=1, wdata=0x12345678; then tx_wr with 0xAA. Read-back with 0x01 -> tx bytes 0x78,0x56,0x34,0x12.
- Bad address: rx 0x05 -> no reg_read; tx 0x55. Rx 0x85 plus 4 data bytes -> no reg_write; tx 0x55.
- Timeout: rx 0x80,0x11, then idle TIMEOUT_CYCLES+1 cycles -> no strobe, busy=0. Then a new 0x00 read frame is serviced normally.
- Backpressure: tx_full=1 for 50 cycles during a read response -> tx_wr stays 0 and the bytes are delivered in order after release, none lost or duplicated.
- Reset mid-frame: assert rst after the 2nd data byte of a write -> no reg_write; all outputs 0. The next frame works.
- CSUM_EN: frame 0x82,0x01,0x00,0x00,0x00 with checksum 0x83 -> write then 0xAA. The same frame with checksum 0x00 -> no write, 0x55.

Source files
------------

// File: rtl/uart2wifi_core_pkg.sv
// uart2wifi_core_pkg: shared FSM state encoding and protocol constants for the register bridge.
// Optional macro UART2WIFI_REGBRIDGE_CSUM_EN adds the GET_CSUM state.
package uart2wifi_core_pkg;

`ifdef UART2WIFI_REGBRIDGE_CSUM_EN
    typedef enum logic [2:0] {
        IDLE, GET_DATA, DO_WRITE, DO_READ, WAIT_RD, SEND_RESP, SEND_DATA, GET_CSUM
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, GET_DATA, DO_WRITE, DO_READ, WAIT_RD, SEND_RESP, SEND_DATA
    } state_t;
`endif

    localparam logic [7:0] ACK_BYTE   = 8'hAA;
    localparam logic [7:0] NAK_BYTE   = 8'h55;
    localparam int         CMD_WR_BIT = 7;

endpackage

// File: rtl/uart2wifi_core_bytetimer.sv
// uart2wifi_core_bytetimer: loadable down-counter flagging an expired inter-byte gap.
// Ports: clk, rst (async, active-high), load (reload to CYCLES), en (count down),
//        expired (counter has reached zero).
module uart2wifi_core_bytetimer #(
    parameter int CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int W = $clog2(CYCLES + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= W'(CYCLES);
        else if (en && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign expired = cnt == '0;

endmodule

// File: rtl/uart2wifi_core_regbridge.sv
// uart2wifi_core_regbridge: decodes UART command frames into register read/write strobes
// and returns ACK/NAK or read data over the TX byte path.
// Ports: clk, rst (async, active-high); rx_valid/rx_data (received bytes);
//        tx_full (TX backpressure), tx_wr/tx_data (TX bytes);
//        reg_addr/reg_wdata/reg_write/reg_read/reg_rdata (register file access);
//        busy (FSM not idle).
// Optional macro UART2WIFI_REGBRIDGE_CSUM_EN: XOR checksum byte on every frame and read response.
module uart2wifi_core_regbridge #(
    parameter int NUM_REGS       = 3,
    parameter int DATA_W         = 32,
    parameter int RD_LATENCY     = 1,
    parameter int TIMEOUT_CYCLES = 163 * 16 * 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              tx_full,
    output logic              tx_wr,
    output logic [7:0]        tx_data,
    output logic [6:0]        reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_write,
    output logic              reg_read,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              busy
);

    import uart2wifi_core_pkg::*;

    localparam int BYTES = DATA_W / 8;
`ifdef UART2WIFI_REGBRIDGE_CSUM_EN
    localparam int TX_BYTES = BYTES + 1;
`else
    localparam int TX_BYTES = BYTES;
`endif
    localparam int CW = $clog2(TX_BYTES + 1);
    localparam int LW = $clog2(RD_LATENCY + 1);
    localparam logic [CW-1:0] LAST_RX   = CW'(BYTES - 1);
    localparam logic [CW-1:0] LAST_TX   = CW'(TX_BYTES - 1);
    localparam logic [LW-1:0] LAST_LAT  = LW'(RD_LATENCY - 1);
    localparam logic [6:0]    REG_LIMIT = 7'(NUM_REGS);

    state_t            state, state_n;
    logic [6:0]        addr;
    logic [7:0]        resp;
    logic [CW-1:0]     byte_cnt;
    logic [LW-1:0]     lat_cnt;
    logic [DATA_W-1:0] data;
    logic              in_frame, expired, legal;
    // Sticky: a byte arrived while no frame could accept it. Debug-only, no port reads it.
    logic              overrun_unused;
    logic [7:0]        tx_byte;

`ifdef UART2WIFI_REGBRIDGE_CSUM_EN
    logic       is_wr;
    logic [7:0] csum, rd_csum;

    always_comb begin
        rd_csum = '0;
        for (int i = 0; i < BYTES; i++)
            rd_csum ^= reg_rdata[i*8 +: 8];
    end

    assign in_frame = state == GET_DATA || state == GET_CSUM;
    // The byte after the data is the checksum captured when the read data was latched.
    assign tx_byte  = byte_cnt == CW'(BYTES) ? csum : data[7:0];
`else
    assign in_frame = state == GET_DATA;
    assign tx_byte  = data[7:0];
`endif

    assign legal = addr < REG_LIMIT;

    uart2wifi_core_bytetimer #(.CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (rx_valid),
        .en      (in_frame),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
`ifdef UART2WIFI_REGBRIDGE_CSUM_EN
            IDLE:      if (rx_valid) state_n = rx_data[CMD_WR_BIT] ? GET_DATA : GET_CSUM;
            GET_DATA:  if (rx_valid && byte_cnt == LAST_RX) state_n = GET_CSUM;
                       else if (expired) state_n = IDLE;
            GET_CSUM:  if (rx_valid) state_n = (csum == rx_data && legal) ? (is_wr ? DO_WRITE : DO_READ) : SEND_RESP;
                       else if (expired) state_n = IDLE;
`else
            IDLE:      if (rx_valid) state_n = rx_data[CMD_WR_BIT] ? GET_DATA :
                                               (rx_data[6:0] < REG_LIMIT) ? DO_READ : SEND_RESP;
            GET_DATA:  if (rx_valid && byte_cnt == LAST_RX) state_n = legal ? DO_WRITE : SEND_RESP;
                       else if (expired) state_n = IDLE;
`endif
            DO_WRITE:  state_n = SEND_RESP;
            DO_READ:   state_n = WAIT_RD;
            WAIT_RD:   if (lat_cnt == LAST_LAT) state_n = SEND_DATA;
            SEND_RESP: if (!tx_full) state_n = IDLE;
            SEND_DATA: if (!tx_full && byte_cnt == LAST_TX) state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr           <= '0;
            resp           <= '0;
            byte_cnt       <= '0;
            lat_cnt        <= '0;
            data           <= '0;
            overrun_unused <= 1'b0;
`ifdef UART2WIFI_REGBRIDGE_CSUM_EN
            is_wr          <= 1'b0;
            csum           <= '0;
`endif
        end else begin
            if (rx_valid && state != IDLE && !in_frame)
                overrun_unused <= 1'b1;
            // Only a completed write earns an ACK; every other route into SEND_RESP is a NAK.
            if (state_n == SEND_RESP && state != SEND_RESP)
                resp <= state == DO_WRITE ? ACK_BYTE : NAK_BYTE;
            case (state)
                IDLE: if (rx_valid) begin
                    addr     <= rx_data[6:0];
                    byte_cnt <= '0;
`ifdef UART2WIFI_REGBRIDGE_CSUM_EN
                    is_wr    <= rx_data[CMD_WR_BIT];
                    csum     <= rx_data;
`endif
                end
                GET_DATA: if (rx_valid) begin
                    // LSB-first: each byte enters at the top and shifts down.
                    data     <= (data >> 8) | (DATA_W'(rx_data) << (DATA_W - 8));
                    byte_cnt <= byte_cnt + 1'b1;
`ifdef UART2WIFI_REGBRIDGE_CSUM_EN
                    csum     <= csum ^ rx_data;
`endif
                end
                DO_READ: lat_cnt <= '0;
                WAIT_RD: begin
                    lat_cnt <= lat_cnt + 1'b1;
                    if (lat_cnt == LAST_LAT) begin
                        data     <= reg_rdata;
                        byte_cnt <= '0;
`ifdef UART2WIFI_REGBRIDGE_CSUM_EN
                        csum     <= rd_csum;
`endif
                    end
                end
                SEND_DATA: if (!tx_full) begin
                    data     <= data >> 8;
                    byte_cnt <= byte_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        reg_write = state == DO_WRITE;
        reg_read  = state == DO_READ;
        reg_addr  = addr;
        reg_wdata = data;
        busy      = state != IDLE;
        tx_wr     = (state == SEND_RESP || state == SEND_DATA) && !tx_full;
        tx_data   = !tx_wr ? 8'h00 : state == SEND_RESP ? resp : tx_byte;
    end

endmodule

// File: tb/tb_uart2wifi_core_regbridge.sv
// tb_uart2wifi_core_regbridge: directed, table-driven bench for uart2wifi_core_regbridge.
// Honours UART2WIFI_REGBRIDGE_CSUM_EN by appending/expecting checksum bytes.
module tb_uart2wifi_core_regbridge;

    localparam int T_OUT = 163 * 16 * 11;

    logic        clk = 1'b0, rst = 1'b1;
    logic        rx_valid = 1'b0, tx_full = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_wr, reg_write, reg_read, busy;
    logic [7:0]  tx_data;
    logic [6:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata = 32'h0;

    always #5 clk = ~clk;

    uart2wifi_core_regbridge dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .tx_full   (tx_full),
        .tx_wr     (tx_wr),
        .tx_data   (tx_data),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_write (reg_write),
        .reg_read  (reg_read),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    // Register file stub with one cycle of read latency.
    logic [31:0] regs [0:127];
    always @(posedge clk) begin
        if (reg_write) regs[reg_addr] <= reg_wdata;
        if (reg_read) reg_rdata <= regs[reg_addr];
    end

    int          n_wr = 0, n_rd = 0;
    logic [6:0]  wr_addr;
    logic [31:0] wr_data;
    logic [7:0]  txq [$];
    bit          overlap = 0, tx_while_full = 0;

    always @(negedge clk) begin
        if (reg_write) begin
            n_wr++;
            wr_addr = reg_addr;
            wr_data = reg_wdata;
        end
        if (reg_read) n_rd++;
        if (tx_wr) txq.push_back(tx_data);
        if (reg_write && reg_read) overlap = 1;
        if (tx_wr && tx_full) tx_while_full = 1;
    end

    int n_checks = 0, n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [31:0] d);
        logic [7:0] cs;
        cs = cmd;
        send_byte(cmd);
        if (cmd[7])
            for (int i = 0; i < 4; i++) begin
                send_byte(d[i*8 +: 8]);
                cs ^= d[i*8 +: 8];
            end
`ifdef UART2WIFI_REGBRIDGE_CSUM_EN
        send_byte(cs);
`endif
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 200 && busy; i++) @(negedge clk);
        check({name, " idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic expect_tx(input string name, input bit is_data, input logic [31:0] w);
        logic [7:0] exp [$];
        logic [7:0] cs;
        cs = 8'h00;
        if (is_data) begin
            for (int i = 0; i < 4; i++) begin
                exp.push_back(w[i*8 +: 8]);
                cs ^= w[i*8 +: 8];
            end
`ifdef UART2WIFI_REGBRIDGE_CSUM_EN
            exp.push_back(cs);
`endif
        end else
            exp.push_back(w[7:0]);
        check({name, " tx count"}, txq.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            check({name, $sformatf(" tx[%0d]", i)}, i < txq.size() ? {24'd0, txq[i]} : 32'hxxxx_xxxx, {24'd0, exp[i]});
    endtask

    typedef struct {
        logic [7:0]  cmd;
        logic [31:0] data;
        bit          exp_wr;
        bit          exp_rd;
        bit          is_data;
        logic [31:0] exp_word;
    } vec_t;

    task automatic run_vec(input string name, input vec_t v);
        int w0, r0;
        w0 = n_wr;
        r0 = n_rd;
        txq.delete();
        send_frame(v.cmd, v.data);
        wait_idle(name);
        check({name, " writes"}, n_wr - w0, {31'd0, v.exp_wr});
        check({name, " reads"}, n_rd - r0, {31'd0, v.exp_rd});
        if (v.exp_wr) begin
            check({name, " waddr"}, {25'd0, wr_addr}, {25'd0, v.cmd[6:0]});
            check({name, " wdata"}, wr_data, v.data);
        end
        expect_tx(name, v.is_data, v.exp_word);
    endtask

    vec_t vecs [11];

    initial begin
        int w0, r0;
        for (int i = 0; i < 128; i++) regs[i] = 32'h0;
        vecs[0]  = '{8'h81, 32'h12345678, 1, 0, 0, 32'hAA};
        vecs[1]  = '{8'h01, 32'h0,        0, 1, 1, 32'h12345678};
        vecs[2]  = '{8'h05, 32'h0,        0, 0, 0, 32'h55};
        vecs[3]  = '{8'h85, 32'hCAFEBABE, 0, 0, 0, 32'h55};
        vecs[4]  = '{8'h82, 32'hDEADBEEF, 1, 0, 0, 32'hAA};
        vecs[5]  = '{8'h02, 32'h0,        0, 1, 1, 32'hDEADBEEF};
        vecs[6]  = '{8'h03, 32'h0,        0, 0, 0, 32'h55};
        vecs[7]  = '{8'hFF, 32'h01020304, 0, 0, 0, 32'h55};
        vecs[8]  = '{8'h00, 32'h0,        0, 1, 1, 32'h0};
        vecs[9]  = '{8'h80, 32'hA5A55A5A, 1, 0, 0, 32'hAA};
        vecs[10] = '{8'h00, 32'h0,        0, 1, 1, 32'hA5A55A5A};

        repeat (3) @(negedge clk);
        check("reset tx_wr", {31'd0, tx_wr}, 0);
        check("reset busy", {31'd0, busy}, 0);
        check("reset strobes", {30'd0, reg_write, reg_read}, 0);
        check("reset wdata", reg_wdata, 0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Read latency: reg_read one cycle after the final frame byte, first tx_wr two cycles later.
        txq.delete();
        send_frame(8'h01, 32'h0);
        check("rdlat reg_read", {31'd0, reg_read}, 1);
        @(negedge clk);
        check("rdlat gap", {30'd0, reg_read, tx_wr}, 0);
        @(negedge clk);
        check("rdlat tx_wr", {31'd0, tx_wr}, 1);
        check("rdlat tx_data", {24'd0, tx_data}, 32'h78);
        wait_idle("rdlat");

        // Write latency: reg_write one cycle after last byte, ACK the cycle after.
        send_frame(8'h81, 32'h11223344);
        check("wrlat reg_write", {31'd0, reg_write}, 1);
        check("wrlat addr", {25'd0, reg_addr}, 1);
        check("wrlat wdata", reg_wdata, 32'h11223344);
        @(negedge clk);
        check("wrlat single strobe", {31'd0, reg_write}, 0);
        check("wrlat tx_wr", {31'd0, tx_wr}, 1);
        check("wrlat ack", {24'd0, tx_data}, 32'hAA);
        wait_idle("wrlat");

        // Backpressure: 50 stalled cycles, then the whole response in order.
        tx_full = 1'b1;
        txq.delete();
        send_frame(8'h01, 32'h0);
        repeat (50) @(negedge clk);
        check("bp held tx", txq.size(), 0);
        check("bp busy", {31'd0, busy}, 1);
        tx_full = 1'b0;
        wait_idle("bp");
        expect_tx("bp", 1, 32'h11223344);

        // Inter-byte timeout drops a partial write silently.
        w0 = n_wr;
        r0 = n_rd;
        txq.delete();
        send_byte(8'h80);
        send_byte(8'h11);
        repeat (T_OUT - 5) @(negedge clk);
        check("tmo before expiry", {31'd0, busy}, 1);
        repeat (6) @(negedge clk);
        check("tmo after expiry", {31'd0, busy}, 0);
        check("tmo strobes", (n_wr - w0) + (n_rd - r0), 0);
        check("tmo tx", txq.size(), 0);
        run_vec("post tmo", '{8'h00, 32'h0, 0, 1, 1, 32'hA5A55A5A});

        // Reset in the middle of a write frame.
        w0 = n_wr;
        txq.delete();
        send_byte(8'h81);
        send_byte(8'hEE);
        send_byte(8'hDD);
        rst = 1'b1;
        #1;
        check("rst busy", {31'd0, busy}, 0);
        check("rst tx", {23'd0, tx_wr, tx_data}, 0);
        check("rst strobes", {30'd0, reg_write, reg_read}, 0);
        check("rst addr", {25'd0, reg_addr}, 0);
        check("rst wdata", reg_wdata, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("rst no write", n_wr - w0, 0);
        check("rst no tx", txq.size(), 0);
        run_vec("post rst", '{8'h01, 32'h0, 0, 1, 1, 32'h11223344});

`ifdef UART2WIFI_REGBRIDGE_CSUM_EN
        w0 = n_wr;
        txq.delete();
        foreach (vecs[i]) if (i < 1) begin end
        send_byte(8'h82); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h83);
        wait_idle("csum good");
        check("csum good write", n_wr - w0, 1);
        check("csum good wdata", wr_data, 32'h1);
        expect_tx("csum good", 0, 32'hAA);
        w0 = n_wr;
        txq.delete();
        send_byte(8'h82); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h00);
        wait_idle("csum bad");
        check("csum bad write", n_wr - w0, 0);
        expect_tx("csum bad", 0, 32'h55);
`endif

        check("no rd/wr overlap", {31'd0, overlap}, 0);
        check("no tx while full", {31'd0, tx_while_full}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
